// File: rtl/sqr_meas.sv
// sqr_meas: hysteresis slicer plus period / high-time / level measurement of a sampled square wave.
// Optional macro SQR_MEAS_AVG4_EN reports the average of four consecutive cycles instead of every cycle.
module sqr_meas #(
  parameter int DATA_W = 14,
  parameter int CNT_W  = 24,
  parameter int THR    = 8192,
  parameter int HYST   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sample_vld,
  input  logic [DATA_W-1:0] sample_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DATA_W-1:0] level_hi,
  output logic [DATA_W-1:0] level_lo,
  output logic              meas_valid,
  output logic              timeout,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, SEEK, HIGH, LOW} state_t;

  localparam logic [DATA_W-1:0] RISE_THR = DATA_W'(THR + HYST);
  localparam logic [DATA_W-1:0] FALL_THR = DATA_W'(THR - HYST);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic              level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_time_q, high_time_d;
  logic [DATA_W-1:0] level_hi_q, level_hi_d;
  logic [DATA_W-1:0] level_lo_q, level_lo_d;
  logic              meas_valid_q, meas_valid_d;
  logic              timeout_q, timeout_d;
  logic              accept, rise, fall, done;

`ifdef SQR_MEAS_AVG4_EN
  localparam int SUM_W = CNT_W + 2;
  logic [SUM_W-1:0]  sum_p_q, sum_p_d;
  logic [SUM_W-1:0]  sum_h_q, sum_h_d;
  logic [DATA_W-1:0] acc_max_q, acc_max_d;
  logic [DATA_W-1:0] acc_min_q, acc_min_d;
  logic [1:0]        acc_n_q, acc_n_d;
  logic [SUM_W-1:0]  tot_p, tot_h;
  logic [DATA_W-1:0] cyc_max, cyc_min;
`endif

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    max_d        = max_q;
    min_d        = min_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    level_hi_d   = level_hi_q;
    level_lo_d   = level_lo_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    done         = 1'b0;

    // The comparator tracks every accepted sample, whatever the FSM is doing.
    accept = en && sample_vld;
    rise   = accept && !level_q && (sample_in >= RISE_THR);
    fall   = accept && level_q && (sample_in <= FALL_THR);
    if (rise) begin
      level_d = 1'b1;
    end else if (fall) begin
      level_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (en) state_d = SEEK;
      end
      SEEK: begin
        if (rise) begin
          cnt_d   = CNT_W'(1);
          hcnt_d  = CNT_W'(1);
          max_d   = sample_in;
          min_d   = '1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (accept) begin
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = SEEK;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (fall) begin
              min_d   = sample_in;
              state_d = LOW;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
              if (sample_in > max_q) max_d = sample_in;
            end
          end
        end
      end
      LOW: begin
        if (rise) begin
          done    = 1'b1;
          cnt_d   = CNT_W'(1);
          hcnt_d  = CNT_W'(1);
          max_d   = sample_in;
          min_d   = '1;
          state_d = HIGH;
        end else if (accept) begin
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = SEEK;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (sample_in < min_q) min_d = sample_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end

`ifdef SQR_MEAS_AVG4_EN
    sum_p_d   = sum_p_q;
    sum_h_d   = sum_h_q;
    acc_max_d = acc_max_q;
    acc_min_d = acc_min_q;
    acc_n_d   = acc_n_q;
    tot_p     = sum_p_q + SUM_W'(cnt_q);
    tot_h     = sum_h_q + SUM_W'(hcnt_q);
    cyc_max   = (max_q > acc_max_q) ? max_q : acc_max_q;
    cyc_min   = (min_q < acc_min_q) ? min_q : acc_min_q;
    // A saturation shows up as HIGH/LOW falling back to SEEK; it spoils the running average.
    if (!en || (state_d == SEEK && (state_q == HIGH || state_q == LOW))) begin
      sum_p_d   = '0;
      sum_h_d   = '0;
      acc_max_d = '0;
      acc_min_d = '1;
      acc_n_d   = '0;
    end else if (done) begin
      if (acc_n_q == 2'd3) begin
        period_d     = CNT_W'(tot_p >> 2);
        high_time_d  = CNT_W'(tot_h >> 2);
        level_hi_d   = cyc_max;
        level_lo_d   = cyc_min;
        meas_valid_d = 1'b1;
        timeout_d    = 1'b0;
        sum_p_d      = '0;
        sum_h_d      = '0;
        acc_max_d    = '0;
        acc_min_d    = '1;
        acc_n_d      = '0;
      end else begin
        sum_p_d   = tot_p;
        sum_h_d   = tot_h;
        acc_max_d = cyc_max;
        acc_min_d = cyc_min;
        acc_n_d   = acc_n_q + 2'd1;
      end
    end
`else
    if (done) begin
      period_d     = cnt_q;
      high_time_d  = hcnt_q;
      level_hi_d   = max_q;
      level_lo_d   = min_q;
      meas_valid_d = 1'b1;
      timeout_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      level_q      <= 1'b0;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      max_q        <= '0;
      min_q        <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      level_hi_q   <= '0;
      level_lo_q   <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef SQR_MEAS_AVG4_EN
      sum_p_q      <= '0;
      sum_h_q      <= '0;
      acc_max_q    <= '0;
      acc_min_q    <= '1;
      acc_n_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      max_q        <= max_d;
      min_q        <= min_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      level_hi_q   <= level_hi_d;
      level_lo_q   <= level_lo_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
`ifdef SQR_MEAS_AVG4_EN
      sum_p_q      <= sum_p_d;
      sum_h_q      <= sum_h_d;
      acc_max_q    <= acc_max_d;
      acc_min_q    <= acc_min_d;
      acc_n_q      <= acc_n_d;
`endif
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign level_hi   = level_hi_q;
  assign level_lo   = level_lo_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/sqr_meas.md
Name: sqr_meas

Overview:
- Receive-side counterpart of the square-wave generator: consumes a 14-bit DAC-domain sample stream, slices it with a hysteresis comparator, and measures period, high time, high level and low level of each cycle.
- Sits on the loopback/monitor path: generator output (or ADC capture) in, measurement registers out to the control/display state logic.
- Used for self-test of freq/amp settings and for closed-loop calibration.

Parameters:
- DATA_W, 14, sample width (matches DAC word).
- CNT_W, 24, width of period/high-time counters.
- THR, 8192, comparator midpoint (unsigned code).
- HYST, 256, hysteresis half-width. Rising threshold = THR+HYST. Falling threshold = THR-HYST.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  measurement enable
- sample_vld  in  1  sample_in valid this cycle
- sample_in  in  DATA_W  unsigned sample code
- period  out  CNT_W  samples per full cycle, last completed measurement
- high_time  out  CNT_W  samples classified high in that cycle
- level_hi  out  DATA_W  max sample seen during the high phase
- level_lo  out  DATA_W  min sample seen during the low phase
- meas_valid  out  1  one-cycle pulse when the outputs above update
- timeout  out  1  sticky flag: counter saturated with no edge; cleared by rst or by the next meas_valid
- busy  out  1  high when in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge, overrides all other inputs): state=IDLE, comparator level=0, all counters 0, period/high_time/level_hi/level_lo=0, meas_valid=0, timeout=0.
- Only accepted samples advance logic. An accepted sample has en=1 and sample_vld=1. Cycles with sample_vld=0 hold all state.
- Comparator (updated on each accepted sample):
  - level 0->1 when sample_in >= THR+HYST.
  - level 1->0 when sample_in <= THR-HYST.
  - Otherwise the level holds.
  - Rising edge = accepted sample that sets level 0->1. That sample counts as the first high sample.
- FSM:
  - IDLE: wait for en=1, then go to SEEK. The comparator runs in SEEK as well.
  - SEEK: discard samples until a rising edge. On the edge: cnt=1, hcnt=1, max=sample, min=all-ones; go to HIGH.
  - HIGH: each accepted sample does cnt+=1.
    - If the comparator stays high: hcnt+=1, max=max(max,sample).
    - If it falls: min=sample; go to LOW.
  - LOW: each accepted sample that is not a rising edge does cnt+=1, min=min(min,sample).
    - On a rising edge, latch period=cnt, high_time=hcnt, level_hi=max, level_lo=min.
    - Pulse meas_valid the next cycle and clear timeout.
    - Restart counters with the edge sample (cnt=1, hcnt=1, max=sample, min=all-ones) and go to HIGH. Measurement is continuous, with no dead cycle.
- Latency: meas_valid asserts exactly 1 clk after the clk edge that accepts the terminating rising-edge sample. Output registers update on that same edge.
- Saturation: if cnt would exceed 2^CNT_W-1 in HIGH or LOW:
  - set timeout=1 and go to SEEK;
  - the comparator keeps its level;
  - outputs hold and meas_valid is not pulsed.
- en=0 while in any non-IDLE state: return to IDLE on that edge. Partial counts are discarded, outputs and timeout hold, and no meas_valid is pulsed.
- Arithmetic: all compares are unsigned. Counters never wrap.

Optional Feature:
- Macro: SQR_MEAS_AVG4_EN.
- Defined:
  - Completed cycles accumulate into CNT_W+2-bit sums for period and high_time.
  - Every 4th completed cycle, period=sum_p>>2 and high_time=sum_h>>2 (truncated). level_hi is the max of the 4 cycles; level_lo is the min.
  - meas_valid pulses only then. Accumulators clear on rst, en=0, timeout, and after each output.
- Undefined: per-cycle update exactly as above; no accumulators are synthesized.

Test Plan:
- Square 0/16383, 100 samples/period, 50 high, sample_vld=1 continuously -> first meas_valid 1 clk after the 2nd rising edge; period=100, high_time=50, level_hi=16383, level_lo=0; meas_valid repeats every 100 clks.
- Input toggling 8100/8300 each sample, then a jump to 9000 -> no comparator toggle before 9000 (within hysteresis); SEEK->HIGH only on the 9000 sample.
- Same 100-sample wave with sample_vld=1 on every other clk -> period=100, high_time=50; meas_valid spacing 200 clks.
- CNT_W=8, input held at 12000 after a rising edge -> timeout=1 after 255 counted samples, state SEEK, no meas_valid. A subsequent valid 40-sample wave -> period=40 and timeout cleared.
- rst asserted mid-HIGH, then mid-LOW -> all outputs 0 next clk. en dropped mid-cycle -> IDLE, outputs hold prior values, busy=0.
- SQR_MEAS_AVG4_EN, periods 100,102,98,104 with high 50,51,49,52 -> single meas_valid; period=101, high_time=50.
